pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register: the successor to the fixed per-field inter-stage latches.
- Carries a generic data payload plus a control field between any two pipeline stages (fetch→decode through memory→writeback).
- Adds a valid/ready handshake with a 2-entry skid buffer, so stalls do not create a combinational ready path, and a flush that inserts bubbles.
- Includes a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 64, payload width in bits (e.g. memOut/aluFinal/addPC/imm concatenated by the instantiating stage).
- CTRL_W, 3, control width in bits (e.g. wbDataSel, regWrt); forced to 0 whenever the output is not valid.
- CNT_W, 16, stall counter width in bits.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream stage presents a valid entry
- in_ready  output  1  stage can accept an entry; registered only
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control
- flush  input  1  squash all held entries (branch/exception)
- out_valid  output  1  downstream entry valid
- out_ready  input  1  downstream accepts the entry
- out_data  output  DATA_W  payload to the next stage
- out_ctrl  output  CTRL_W  control to the next stage; 0 when out_valid=0
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 && out_ready=0
- stall_clr  input  1  synchronous clear of stall_cnt

Behaviour:
- Reset (rst=0, asynchronous):
  - all state cleared; state=EMPTY.
  - out_valid=0, out_data=0, out_ctrl=0, in_ready=1, stall_cnt=0.
- Transfers:
  - push = in_valid && in_ready; pop = out_valid && out_ready; both sampled at the rising edge.
- Storage:
  - main register drives the outputs; skid register holds the one entry accepted while the output was blocked.
- States:
  - EMPTY: push → ONE.
  - ONE:
    - push && pop → ONE, main loads in_data.
    - push && !pop → FULL, skid loads in_data.
    - pop && !push → EMPTY.
    - neither → hold.
  - FULL:
    - in_ready=0, so push is impossible.
    - pop → ONE, main loads skid.
    - no pop → hold.
- in_ready is 1 in EMPTY and ONE, 0 in FULL. It is driven directly from state flops and never depends on out_ready.
- Timing:
  - latency 1 cycle in → out when not blocked.
  - sustained throughput 1 entry/cycle with out_ready held 1.
  - ordering is strictly FIFO.
- Flush:
  - takes priority over push and pop in the same cycle; the incoming entry is dropped.
  - next state is EMPTY; out_ctrl=0 and out_valid=0 from the next cycle.
  - out_data is don't-care after flush; the bench must not check it.
- Bubble guarantee: out_ctrl is 0 in every cycle where out_valid=0. This is enforced at the register, not by gating downstream.
- Data path rules:
  - payload is never modified.
  - DATA_W and CTRL_W must each be ≥1.
  - when CTRL_W is unused, tie off with a 1-bit constant 0.
- stall_cnt:
  - increments on each cycle with out_valid && !out_ready.
  - saturates at all-ones with no wrap.
  - stall_clr has priority over increment.
  - flush does not clear stall_cnt.
- Reset mid-operation: any held entries are lost immediately (asynchronous); the first push after rst deasserts behaves as from EMPTY.

Decomposition:
- Shared pipeline package:
  - state encoding localparams: EMPTY=2'd0, ONE=2'd1, FULL=2'd2; 2'd3 is illegal and recovers to EMPTY.
  - default width constants per pipe boundary (F2D, D2X, X2M, M2W payload/ctrl widths).
- One sub-module: sat_counter (CNT_W parameter; inc, clr inputs; saturating).
- The existing bit-level dff cell is not used. The stage registers need enables and asynchronous active-low reset, so they are written as behavioural registers inside this block.

Test Plan:
- Reset: hold rst=0, drive in_valid=1 with in_data=0xDEAD → out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0 throughout reset.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles with in_ctrl=3'b101 → outputs 0x1,0x2,0x3 one cycle later, back to back; in_ready stays 1.
- Backpressure/skid: push 0xA, 0xB, then out_ready=0 for 3 cycles →
  - FULL reached; in_ready=0 on the cycle after the 0xB push.
  - out_data holds 0xA.
  - stall_cnt=3.
  - when out_ready=1 is released: 0xA then 0xB delivered, no loss or duplicate.
- Flush priority: in FULL, assert flush with in_valid=1 and out_ready=1 → next cycle out_valid=0, out_ctrl=0, in_ready=1; neither the flushed entries nor the incoming entry ever appears.
- Counter: CNT_W=2, hold stall for 5 cycles → stall_cnt=3 (saturated); assert stall_clr together with a stall → stall_cnt=0.
- Async reset mid-stream: drop rst between clock edges while in ONE → out_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for valid/ready pipeline stages: state encoding of the
// two-entry skid stage and default payload/control widths per pipe boundary.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ONE     = 2'd1,
    FULL    = 2'd2,
    ILLEGAL = 2'd3
  } skid_state_e;

  localparam int unsigned F2D_DATA_W = 64;
  localparam int unsigned F2D_CTRL_W = 3;
  localparam int unsigned D2X_DATA_W = 64;
  localparam int unsigned D2X_CTRL_W = 3;
  localparam int unsigned X2M_DATA_W = 64;
  localparam int unsigned X2M_CTRL_W = 3;
  localparam int unsigned M2W_DATA_W = 64;
  localparam int unsigned M2W_CTRL_W = 3;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// bubble-inserting flush and a saturating stall-cycle counter.
//
// state | meaning
// EMPTY | no entry held; outputs are a bubble
// ONE   | main register holds the output entry
// FULL  | main drives output, skid holds the next entry; in_ready=0
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              push, pop;

  // Handshake outputs come straight from state flops: no out_ready path.
  assign in_ready  = (state_q == EMPTY) || (state_q == ONE);
  assign out_valid = (state_q == ONE) || (state_q == FULL);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (push) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (pop) begin
            // Bubble is written into the register so out_ctrl is 0 on its own.
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        FULL: begin
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (out_valid && !out_ready),
    .clr_i  (stall_clr),
    .cnt_o  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, hand-written
// reset/counter sequences and randomized traffic against a queue-based model.
module tb_pipe_stage_skid;

  localparam int DW = 64;
  localparam int CW = 3;
  localparam int NW = 16;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, out_valid, out_ready, stall_clr;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [NW-1:0] stall_cnt;

  logic       s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready, s_stall_clr;
  logic [7:0] s_in_data, s_out_data;
  logic [0:0] s_in_ctrl, s_out_ctrl;
  logic [1:0] s_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_skid #(.DATA_W(8), .CTRL_W(1), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .stall_cnt(s_stall_cnt), .stall_clr(s_stall_clr)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_cnt;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          fl;
    logic          ordy;
    logic          clr;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic          er;
    logic [NW-1:0] ecnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0;
  endtask

  // Model view: the stage is a 2-deep FIFO; in_ready/out_valid follow occupancy
  // at the start of the cycle.
  task automatic tick();
    logic mv, mr;
    ent_t e;
    mv = (mq.size() != 0);
    mr = (mq.size() < 2);
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (mv && out_ready) void'(mq.pop_front());
      if (in_valid && mr) begin
        e.d = in_data;
        e.c = in_ctrl;
        mq.push_back(e);
      end
    end
    if (stall_clr) m_cnt = 0;
    else if (mv && !out_ready && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic check_model(input string tag);
    logic          ev;
    logic [CW-1:0] ec;
    ev = (mq.size() != 0);
    ec = ev ? mq[0].c : '0;
    check({tag, "_valid"}, 64'(out_valid), 64'(ev));
    check({tag, "_ready"}, 64'(in_ready), 64'(mq.size() < 2));
    check({tag, "_ctrl"}, 64'(out_ctrl), 64'(ec));
    check({tag, "_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    if (ev) check({tag, "_data"}, out_data, mq[0].d);
  endtask

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic [CW-1:0] c, logic fl,
                              logic ordy, logic clr, logic ev, logic [DW-1:0] ed,
                              logic [CW-1:0] ec, logic er, logic [NW-1:0] ecnt);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.fl = fl; v.ordy = ordy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.ec = ec; v.er = er; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    // streaming 1,2,3 with ctrl 101
    vecs[0]  = mk(H, 64'h1,  3'd5, L, H, L,  H, 64'h1,  3'd5, H, 16'd0);
    vecs[1]  = mk(H, 64'h2,  3'd5, L, H, L,  H, 64'h2,  3'd5, H, 16'd0);
    vecs[2]  = mk(H, 64'h3,  3'd5, L, H, L,  H, 64'h3,  3'd5, H, 16'd0);
    vecs[3]  = mk(L, 64'h0,  3'd0, L, H, L,  L, 64'h0,  3'd0, H, 16'd0);
    // backpressure into the skid register; 0xC must be refused
    vecs[4]  = mk(H, 64'hA,  3'd2, L, H, L,  H, 64'hA,  3'd2, H, 16'd0);
    vecs[5]  = mk(H, 64'hB,  3'd3, L, L, L,  H, 64'hA,  3'd2, L, 16'd1);
    vecs[6]  = mk(H, 64'hC,  3'd7, L, L, L,  H, 64'hA,  3'd2, L, 16'd2);
    vecs[7]  = mk(L, 64'h0,  3'd0, L, L, L,  H, 64'hA,  3'd2, L, 16'd3);
    vecs[8]  = mk(L, 64'h0,  3'd0, L, H, L,  H, 64'hB,  3'd3, H, 16'd3);
    vecs[9]  = mk(L, 64'h0,  3'd0, L, H, L,  L, 64'h0,  3'd0, H, 16'd3);
    // fill to FULL, then flush with a simultaneous push and pop
    vecs[10] = mk(H, 64'h10, 3'd1, L, L, L,  H, 64'h10, 3'd1, H, 16'd3);
    vecs[11] = mk(H, 64'h11, 3'd1, L, L, L,  H, 64'h10, 3'd1, L, 16'd4);
    vecs[12] = mk(H, 64'h12, 3'd1, H, H, L,  L, 64'h0,  3'd0, H, 16'd4);
    vecs[13] = mk(L, 64'h0,  3'd0, L, H, L,  L, 64'h0,  3'd0, H, 16'd4);
    // stall_clr after flush; flush left the counter alone
    vecs[14] = mk(H, 64'h20, 3'd6, L, H, H,  H, 64'h20, 3'd6, H, 16'd0);
    vecs[15] = mk(L, 64'h0,  3'd0, L, H, L,  L, 64'h0,  3'd0, H, 16'd0);

    rst = 1'b0;
    in_valid = 1'b1; in_data = 64'hDEAD; in_ctrl = 3'd7;
    flush = 1'b0; out_ready = 1'b1; stall_clr = 1'b0;
    s_in_valid = 1'b0; s_in_data = 8'h0; s_in_ctrl = 1'b0;
    s_flush = 1'b0; s_out_ready = 1'b1; s_stall_clr = 1'b0;
    model_reset();

    #2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ctrl",  64'(out_ctrl),  64'd0);
      check("rst_ready", 64'(in_ready),  64'd1);
      check("rst_cnt",   64'(stall_cnt), 64'd0);
    end
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].d; in_ctrl = vecs[i].c;
      flush = vecs[i].fl; out_ready = vecs[i].ordy; stall_clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d_ctrl", i),  64'(out_ctrl),  64'(vecs[i].ec));
      check($sformatf("vec%0d_ready", i), 64'(in_ready),  64'(vecs[i].er));
      check($sformatf("vec%0d_cnt", i),   64'(stall_cnt), 64'(vecs[i].ecnt));
      if (vecs[i].ev) check($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
    end

    // asynchronous reset between edges while holding one entry
    in_valid = 1'b1; in_data = 64'h55; in_ctrl = 3'd7; out_ready = 1'b0;
    flush = 1'b0; stall_clr = 1'b0;
    tick();
    check("arst_pre_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ctrl",  64'(out_ctrl),  64'd0);
    check("arst_ready", 64'(in_ready),  64'd1);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1; in_data = 64'h66; in_ctrl = 3'd4; out_ready = 1'b1;
    tick();
    check_model("arst_post");
    check("arst_post_data", out_data, 64'h66);
    in_valid = 1'b0;
    tick();
    check_model("arst_drain");

    // randomized traffic against the FIFO model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      in_ctrl   = 3'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0) ^ (i[8] & ($urandom_range(0, 1) == 1));
      stall_clr = ($urandom_range(0, 63) == 0);
      tick();
      check_model("rnd");
    end
    in_valid = 1'b0; flush = 1'b0; stall_clr = 1'b0; out_ready = 1'b1;

    // 2-bit stall counter saturation and clear priority
    s_in_valid = 1'b1; s_in_data = 8'h5A; s_in_ctrl = 1'b1; s_out_ready = 1'b0;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    check("sat_start", 64'(s_stall_cnt), 64'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("sat_cnt",   64'(s_stall_cnt), 64'd3);
    check("sat_data",  64'(s_out_data),  64'h5A);
    check("sat_valid", 64'(s_out_valid), 64'd1);
    s_stall_clr = 1'b1;
    @(posedge clk); #1;
    check("sat_clr", 64'(s_stall_cnt), 64'd0);
    s_stall_clr = 1'b0;
    @(posedge clk); #1;
    check("sat_after_clr", 64'(s_stall_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
